// File: rtl/rans_axi_ctrl.sv
// AXI4-Lite control slave for the multi-channel rANS encoder.
//
// Purpose: maps NUM_CHANNELS frequency tables plus a control register page onto an
// AXI4-Lite slave. AW and W are accepted independently into one-entry holding buffers
// and committed together. Commits drive one-cycle pulses for table writes, per-channel
// restart and job start. A STATUS register exposes busy_i and a sticky done bit.
//
// Ports:
//   aclk, aresetn              clock, synchronous active-low reset
//   aw*/w*/b*/ar*/r*           AXI4-Lite slave channels
//   freq_wr_o .. cum_freq_o    frequency-table write port (one-cycle strobe)
//   restart_o                  per-channel one-cycle restart pulse
//   start_o                    one-cycle job start pulse
//   read_addr_o, length_o,
//   write_addr_o               DMA job registers
//   busy_i, done_i             per-channel busy flags, one-cycle job-done pulse
//
// Optional feature: define RANS_AXI_SLVERR_EN to answer unmapped accesses and
// partial-strobe table writes with SLVERR. Undefined, every response is OKAY.

module rans_axi_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RESOLUTION   = 10,
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter logic [ADDR_WIDTH-1:0] CTRL_BASE = 'h8000,
  localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    freq_wr_o,
  output logic [CH_W-1:0]         freq_ch_o,
  output logic [SYMBOL_WIDTH-1:0] freq_addr_o,
  output logic [RESOLUTION-1:0]   freq_o,
  output logic [RESOLUTION-1:0]   cum_freq_o,
  output logic [NUM_CHANNELS-1:0] restart_o,
  output logic                    start_o,
  output logic [DATA_WIDTH-1:0]   read_addr_o,
  output logic [DATA_WIDTH-1:0]   length_o,
  output logic [DATA_WIDTH-1:0]   write_addr_o,
  input  logic [NUM_CHANNELS-1:0] busy_i,
  input  logic                    done_i
);

  localparam int unsigned WA = ADDR_WIDTH - 2;  // word-address width
  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam logic [WA:0]   TableWords = (WA+1)'(NUM_CHANNELS) << SYMBOL_WIDTH;
  localparam logic [WA-1:0] CtrlWord   = CTRL_BASE[ADDR_WIDTH-1:2];
  localparam logic [1:0]    RespOkay   = 2'b00;
  localparam logic [1:0]    RespSlvErr = 2'b10;

  typedef enum logic [2:0] {
    RegNone, RegTable, RegRestart, RegReadAddr, RegLength, RegWriteAddr, RegStart, RegStatus
  } reg_e;

  function automatic reg_e decode(input logic [WA-1:0] w);
    logic [WA-1:0] off;
    off = w - CtrlWord;
    if ({1'b0, w} < TableWords) return RegTable;
    case (off)
      WA'(0):  return RegRestart;
      WA'(1):  return RegReadAddr;
      WA'(2):  return RegLength;
      WA'(3):  return RegWriteAddr;
      WA'(4):  return RegStart;
      WA'(5):  return RegStatus;
      default: return RegNone;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_v,
                                                  input logic [DATA_WIDTH-1:0] new_v,
                                                  input logic [NB-1:0]         strb);
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < int'(NB); i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // State
  logic                    aw_held_q, w_held_q;
  logic [WA-1:0]           aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [NB-1:0]           w_strb_q;
  logic                    bvalid_q, rvalid_q, done_q;
  logic [1:0]              bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q, read_addr_q, length_q, write_addr_q;
  logic                    freq_wr_q, start_q;
  logic [CH_W-1:0]         freq_ch_q;
  logic [SYMBOL_WIDTH-1:0] freq_addr_q;
  logic [RESOLUTION-1:0]   freq_q, cum_q;
  logic [NUM_CHANNELS-1:0] restart_q;

  // Write-side combinational view: the held copy wins, otherwise the live channel.
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [WA-1:0]         wr_word;
  logic [DATA_WIDTH-1:0] wr_data, rd_data;
  logic [NB-1:0]         wr_strb;
  reg_e                  wr_reg, rd_reg;
  logic [1:0]            wr_resp, rd_resp;
  logic                  unused_addr_bits;

  assign awready = aresetn && !aw_held_q;
  assign wready  = aresetn && !w_held_q;
  assign arready = aresetn && (!rvalid_q || rready);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && (!bvalid_q || bready);

  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  always_comb begin
    wr_word = aw_held_q ? aw_addr_q : awaddr[ADDR_WIDTH-1:2];
    wr_data = w_held_q ? w_data_q : wdata;
    wr_strb = w_held_q ? w_strb_q : wstrb;
    wr_reg  = decode(wr_word);
    rd_reg  = decode(araddr[ADDR_WIDTH-1:2]);
    wr_resp = RespOkay;
    rd_resp = RespOkay;
`ifdef RANS_AXI_SLVERR_EN
    if (wr_reg == RegNone || (wr_reg == RegTable && wr_strb != {NB{1'b1}})) begin
      wr_resp = RespSlvErr;
    end
    if (rd_reg == RegNone) rd_resp = RespSlvErr;
`endif
    rd_data = '0;
    case (rd_reg)
      RegReadAddr:  rd_data = read_addr_q;
      RegLength:    rd_data = length_q;
      RegWriteAddr: rd_data = write_addr_q;
      RegStatus:    rd_data = DATA_WIDTH'({15'b0, done_q, 16'(busy_i)});
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RespOkay;
      rvalid_q     <= 1'b0;
      rresp_q      <= RespOkay;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      read_addr_q  <= '0;
      length_q     <= '0;
      write_addr_q <= '0;
      freq_wr_q    <= 1'b0;
      freq_ch_q    <= '0;
      freq_addr_q  <= '0;
      freq_q       <= '0;
      cum_q        <= '0;
      restart_q    <= '0;
      start_q      <= 1'b0;
    end else begin
      freq_wr_q <= 1'b0;
      restart_q <= '0;
      start_q   <= 1'b0;

      if (aw_hs) aw_addr_q <= awaddr[ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      aw_held_q <= commit ? 1'b0 : (aw_held_q || aw_hs);
      w_held_q  <= commit ? 1'b0 : (w_held_q || w_hs);

      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
        unique case (wr_reg)
          RegTable: begin
            if (wr_strb == {NB{1'b1}}) begin
              freq_wr_q   <= 1'b1;
              freq_ch_q   <= wr_word[SYMBOL_WIDTH +: CH_W];
              freq_addr_q <= wr_word[SYMBOL_WIDTH-1:0];
              freq_q      <= wr_data[2*RESOLUTION-1:RESOLUTION];
              cum_q       <= wr_data[RESOLUTION-1:0];
            end
          end
          RegRestart:   restart_q    <= wr_data[NUM_CHANNELS-1:0];
          RegReadAddr:  read_addr_q  <= merge(read_addr_q, wr_data, wr_strb);
          RegLength:    length_q     <= merge(length_q, wr_data, wr_strb);
          RegWriteAddr: write_addr_q <= merge(write_addr_q, wr_data, wr_strb);
          RegStart:     start_q      <= 1'b1;
          RegStatus, RegNone: ;
        endcase
      end else if (bready) begin
        bvalid_q <= 1'b0;
      end

      // A new done pulse beats a simultaneous W1C.
      if (done_i) begin
        done_q <= 1'b1;
      end else if (commit && wr_reg == RegStatus && wr_strb[2] && wr_data[16]) begin
        done_q <= 1'b0;
      end

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign rvalid       = rvalid_q;
  assign rresp        = rresp_q;
  assign rdata        = rdata_q;
  assign freq_wr_o    = freq_wr_q;
  assign freq_ch_o    = freq_ch_q;
  assign freq_addr_o  = freq_addr_q;
  assign freq_o       = freq_q;
  assign cum_freq_o   = cum_q;
  assign restart_o    = restart_q;
  assign start_o      = start_q;
  assign read_addr_o  = read_addr_q;
  assign length_o     = length_q;
  assign write_addr_o = write_addr_q;

endmodule

// File: tb/tb_rans_axi_ctrl.sv
// Directed self-checking bench for rans_axi_ctrl with default parameters.
module tb_rans_axi_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        freq_wr_o, start_o, done_i;
  logic [1:0]  freq_ch_o;
  logic [7:0]  freq_addr_o;
  logic [9:0]  freq_o, cum_freq_o;
  logic [3:0]  restart_o, busy_i;
  logic [31:0] read_addr_o, length_o, write_addr_o;

`ifdef RANS_AXI_SLVERR_EN
  localparam logic [1:0] ErrResp = 2'b10;
`else
  localparam logic [1:0] ErrResp = 2'b00;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 aclk = ~aclk;

  rans_axi_ctrl dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .freq_wr_o(freq_wr_o), .freq_ch_o(freq_ch_o), .freq_addr_o(freq_addr_o),
    .freq_o(freq_o), .cum_freq_o(cum_freq_o), .restart_o(restart_o), .start_o(start_o),
    .read_addr_o(read_addr_o), .length_o(length_o), .write_addr_o(write_addr_o),
    .busy_i(busy_i), .done_i(done_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; awvalid = 1'b1;
    wdata = d;  wstrb = s; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_bvalid", {31'b0, bvalid}, 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    check("rd_rvalid", {31'b0, rvalid}, 32'd1);
    d = rdata;
    r = rresp;
  endtask

  logic [31:0] rd;
  logic [1:0]  rr;

  initial begin
    aresetn = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1; busy_i = '0; done_i = 1'b0;
    tick(); tick();
    check("rst_awready", {31'b0, awready}, 0);
    check("rst_wready", {31'b0, wready}, 0);
    check("rst_arready", {31'b0, arready}, 0);
    check("rst_bvalid", {31'b0, bvalid}, 0);
    check("rst_rvalid", {31'b0, rvalid}, 0);
    check("rst_read_addr", read_addr_o, 0);
    aresetn = 1'b1;
    tick();
    check("ready_after_rst", {29'b0, awready, wready, arready}, 32'h7);

    // Table write: channel 3, symbol 2, freq 0x0A0, cum 0x010.
    axi_write(32'h0C08, 32'h0002_8010, 4'hF);
    check("tbl_wr", {31'b0, freq_wr_o}, 1);
    check("tbl_ch", {30'b0, freq_ch_o}, 3);
    check("tbl_sym", {24'b0, freq_addr_o}, 2);
    check("tbl_freq", {22'b0, freq_o}, 32'h0A0);
    check("tbl_cum", {22'b0, cum_freq_o}, 32'h010);
    check("tbl_bresp", {30'b0, bresp}, 0);
    tick();
    check("tbl_wr_once", {31'b0, freq_wr_o}, 0);
    check("tbl_bvalid_drop", {31'b0, bvalid}, 0);

    // Partial-strobe table write must not fire.
    axi_write(32'h0004, 32'h000F_FFFF, 4'h7);
    check("tbl_partial_wr", {31'b0, freq_wr_o}, 0);
    check("tbl_partial_bresp", {30'b0, bresp}, {30'b0, ErrResp});
    axi_read(32'h0C08, rd, rr);
    check("tbl_rdata", rd, 0);
    check("tbl_rresp", {30'b0, rr}, 0);

    // W first, AW three cycles later, low two lanes only.
    wdata = 32'h1234_5678; wstrb = 4'b0011; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("dec_w_held", {31'b0, wready}, 0);
    check("dec_no_b", {31'b0, bvalid}, 0);
    tick(); tick();
    awaddr = 32'h8004; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("dec_bvalid", {31'b0, bvalid}, 1);
    check("dec_read_addr", read_addr_o, 32'h0000_5678);
    axi_read(32'h8004, rd, rr);
    check("dec_readback", rd, 32'h0000_5678);

    // Backpressure: second write held until first B handshake.
    bready = 1'b0;
    axi_write(32'h8008, 32'hAAAA_0001, 4'hF);
    awaddr = 32'h800C; awvalid = 1'b1; wdata = 32'hBBBB_0002; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("bp_aw_held", {31'b0, awready}, 0);
    check("bp_w_held", {31'b0, wready}, 0);
    check("bp_length", length_o, 32'hAAAA_0001);
    tick(); tick(); tick();
    check("bp_not_yet", write_addr_o, 0);
    check("bp_bvalid_hold", {31'b0, bvalid}, 1);
    bready = 1'b1;
    tick();
    check("bp_second_b", {31'b0, bvalid}, 1);
    check("bp_write_addr", write_addr_o, 32'hBBBB_0002);
    check("bp_awready", {31'b0, awready}, 1);
    tick();
    check("bp_b_done", {31'b0, bvalid}, 0);

    // Restart and start pulses.
    axi_write(32'h8000, 32'h5, 4'hF);
    check("restart_pulse", {28'b0, restart_o}, 32'h5);
    tick();
    check("restart_once", {28'b0, restart_o}, 0);
    axi_write(32'h8010, 32'h0, 4'hF);
    check("start_pulse", {31'b0, start_o}, 1);
    tick();
    check("start_once", {31'b0, start_o}, 0);

    // Byte lanes 1 and 3 of LENGTH.
    axi_write(32'h8008, 32'h1122_3344, 4'b1010);
    check("strb_length", length_o, 32'h11AA_3301);
    tick();

    // Back-to-back writes, one per cycle.
    awaddr = 32'h8004; awvalid = 1'b1; wdata = 32'hCAFE_0001; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    check("b2b_first", read_addr_o, 32'hCAFE_0001);
    check("b2b_awready", {31'b0, awready}, 1);
    wdata = 32'hCAFE_0002;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("b2b_second", read_addr_o, 32'hCAFE_0002);
    check("b2b_bvalid", {31'b0, bvalid}, 1);
    tick();

    // Read data held stable under rready low.
    rready = 1'b0; araddr = 32'h8008; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("rstall_rvalid", {31'b0, rvalid}, 1);
    tick();
    check("rstall_hold", {31'b0, rvalid}, 1);
    check("rstall_data", rdata, 32'h11AA_3301);
    check("rstall_arready", {31'b0, arready}, 0);
    rready = 1'b1;
    tick();
    check("rstall_drop", {31'b0, rvalid}, 0);

    // STATUS: busy + sticky done, W1C vs coincident done.
    busy_i = 4'b0010; done_i = 1'b1;
    tick();
    done_i = 1'b0;
    axi_read(32'h8014, rd, rr);
    check("status_done", rd, 32'h0001_0002);
    done_i = 1'b1;
    axi_write(32'h8014, 32'h0001_0000, 4'hF);
    done_i = 1'b0;
    axi_read(32'h8014, rd, rr);
    check("status_set_wins", rd, 32'h0001_0002);
    axi_write(32'h8014, 32'h0001_0000, 4'hF);
    axi_read(32'h8014, rd, rr);
    check("status_w1c", rd, 32'h0000_0002);

    // Unmapped control address.
    axi_write(32'h8040, 32'hFFFF_FFFF, 4'hF);
    check("unm_bresp", {30'b0, bresp}, {30'b0, ErrResp});
    check("unm_no_effect", read_addr_o, 32'hCAFE_0002);
    axi_read(32'h8040, rd, rr);
    check("unm_rdata", rd, 0);
    check("unm_rresp", {30'b0, rr}, {30'b0, ErrResp});
    tick();

    // Reset while W is held: the held data must be dropped.
    wdata = 32'h0; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("mid_w_held", {31'b0, wready}, 0);
    aresetn = 1'b0;
    tick();
    check("mid_rst_regs", read_addr_o, 0);
    check("mid_rst_wready", {31'b0, wready}, 0);
    aresetn = 1'b1;
    awaddr = 32'h8010; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("mid_no_b", {31'b0, bvalid}, 0);
    check("mid_no_start", {31'b0, start_o}, 0);
    check("mid_wready", {31'b0, wready}, 1);
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("mid_start", {31'b0, start_o}, 1);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rans_axi_ctrl.md
Name: rans_axi_ctrl

Overview:
- AXI4-Lite control slave for the multi-channel rANS encoder. Generalises the single-table control block to NUM_CHANNELS independent frequency tables.
- AW and W channels are decoupled, each with its own one-entry holding buffer. Write byte strobes are honoured.
- Adds a readable STATUS register with a sticky done bit.
- Drives the frequency-table write port, per-channel restart, and the DMA job registers (read address, length, write address, start).

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (fixed at 32)
RESOLUTION, 10, frequency precision in bits
SYMBOL_WIDTH, 8, symbol index width
NUM_CHANNELS, 4, number of rANS channels/tables (1..16)
CTRL_BASE, 'h8000, byte base address of the control register page

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel
wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
bresp/bvalid/bready  out/out/in  2/1/1  write response channel
araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel
rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel
freq_wr_o  out  1  one-cycle table write strobe
freq_ch_o  out  $clog2(NUM_CHANNELS) max 1  target channel of the table write
freq_addr_o  out  SYMBOL_WIDTH  symbol index
freq_o, cum_freq_o  out  RESOLUTION each  frequency, cumulative frequency
restart_o  out  NUM_CHANNELS  one-cycle per-channel restart pulse
start_o  out  1  one-cycle job start pulse
read_addr_o, length_o, write_addr_o  out  32 each  job registers
busy_i  in  NUM_CHANNELS  per-channel busy flags
done_i  in  1  one-cycle job-done pulse

Behaviour:
- Reset (aresetn low at the aclk edge):
  - All held flags, bvalid, rvalid, pulse outputs, job registers and the done bit clear to 0.
  - awready, wready and arready are forced to 0 while aresetn is low.
- Address map (byte addresses, bits [1:0] ignored):
  - Table region: addr < NUM_CHANNELS << (SYMBOL_WIDTH+2). Channel = addr >> (SYMBOL_WIDTH+2); symbol = addr[SYMBOL_WIDTH+1:2].
  - Control page at CTRL_BASE:
    - +0x00 RESTART: W; wdata[NUM_CHANNELS-1:0] is the restart mask; reads as 0.
    - +0x04 READ_ADDR: RW.
    - +0x08 LENGTH: RW.
    - +0x0C WRITE_ADDR: RW.
    - +0x10 START: W; any write pulses start_o; reads as 0.
    - +0x14 STATUS: RO except bit 16. Bits [NUM_CHANNELS-1:0] = busy_i; bit 16 = done sticky (W1C).
  - Any other address is unmapped: writes are ignored; reads return 0.
- Write path:
  - awready = !aw_held; wready = !w_held. A handshake on either channel latches address or data and sets its held flag. The channels may arrive in either order or in the same cycle.
  - Commit occurs in the cycle where both are present (held, or handshaking this cycle) and (!bvalid || bready).
  - On commit: held flags clear, bvalid is 1 on the next cycle, and pulses (freq_wr_o, restart_o, start_o) are high for exactly the next cycle.
  - Table writes fire only if wstrb == 4'hF. Payload is wdata[2*RESOLUTION-1:0] = {freq, cum_freq}.
  - RW registers update per byte lane per wstrb.
  - Back-to-back writes: with bready held high, throughput is one write per cycle.
  - bvalid holds until bready.
- Read path:
  - arready = !rvalid || rready. Read latency is 1 cycle.
  - rdata and rvalid are registered and stable while rvalid && !rready.
  - Table reads return 0.
- Done bit:
  - done_i sets bit 16.
  - A W1C write committing in the same cycle as done_i leaves the bit set (set wins).
- Response codes: bresp = rresp = 2'b00 (OKAY).
- Reset mid-transaction: outstanding held AW/W data are discarded; no pulse is emitted.

Optional Feature:
- Macro: RANS_AXI_SLVERR_EN.
- Defined:
  - Unmapped reads and writes return 2'b10 (SLVERR).
  - Table writes with wstrb != 4'hF return SLVERR.
  - Writes to STATUS bits other than bit 16 remain silently ignored.
- Undefined: all responses are OKAY.

Test Plan:
- Table write, NUM_CHANNELS=4, SYMBOL_WIDTH=8: AW 0x0C08 and W 0x0002_8010, same cycle -> next cycle freq_wr_o=1, freq_ch_o=3, freq_addr_o=2, freq_o=0x0A0, cum_freq_o=0x010; bvalid=1, bresp=0.
- Decoupled channels: W 0x1234_5678 to CTRL_BASE+0x04, AW 3 cycles later, wstrb=4'b0011 -> READ_ADDR=0x0000_5678; read back returns 0x0000_5678 one cycle after the AR handshake.
- Backpressure: bready=0 for 5 cycles over two queued writes -> second commit is delayed until the first B handshake; both register updates are applied; no write is lost.
- RESTART: write 0x5 -> restart_o=4'b0101 for exactly one cycle. START write -> start_o pulses once.
- STATUS: busy_i=4'b0010, done_i pulse, then read -> 0x0001_0002. W1C 0x0001_0000 coincident with done_i -> bit stays 1; the next W1C clears it.
- Unmapped access to CTRL_BASE+0x40: write then read -> rdata=0; resp=OKAY, or SLVERR with RANS_AXI_SLVERR_EN defined.
